// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared decoder/LSU types for the MEM stage
// Purpose: access-size enum, MEM-stage control struct, LSU state enum and the
//          misalignment helper used when LSU_MISALIGN_TRAP_EN is defined.
// Ports:   none (package)
package rv_pkg;

   typedef enum logic [1:0] {
      RW_BYTE  = 2'd0,
      RW_HWORD = 2'd1,
      RW_WORD  = 2'd2,
      RW_RSVD  = 2'd3
   } rw_sz_e;

   typedef struct packed {
      logic   mem_read;
      logic   mem_write;
      logic   sign_ext;
      rw_sz_e rw_sz;
   } mem_ctrl_reg_t;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   // Halfwords need a[0]=0, words need a[1:0]=0; bytes are always aligned.
   function automatic logic lsu_misaligned(input rw_sz_e sz, input logic [1:0] a);
      case (sz)
         RW_BYTE:  return 1'b0;
         RW_HWORD: return a[0];
         default:  return (a != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for the LSU
// Purpose: combinational byte-enable generation, store-data lane replication
//          and load-data extraction with sign/zero extension.
// Ports:   i_sz/i_sign_ext/i_lane  access size, extension mode, byte offset
//          i_wdata -> o_wdata      store data (LSBs) -> lane-replicated
//          i_rdata -> o_rdata      raw bus word -> aligned, extended result
//          o_be                    byte enables
module lsu_lane_align
   import rv_pkg::*;
(
   input  rw_sz_e      i_sz,
   input  logic        i_sign_ext,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [1:0]  w_lane_eff;
   logic [31:0] w_sh;

   // Without the trap, misaligned low bits are dropped: HWORD keeps a[1], WORD uses lane 0.
   always_comb begin
      w_lane_eff = 2'b00;
      case (i_sz)
         RW_BYTE:  w_lane_eff = i_lane;
         RW_HWORD: w_lane_eff = {i_lane[1], 1'b0};
         default:  w_lane_eff = 2'b00;
      endcase
   end

   assign w_sh = i_rdata >> {w_lane_eff, 3'b000};

   always_comb begin
      o_be    = 4'hF;
      o_wdata = i_wdata;
      o_rdata = w_sh;
      case (i_sz)
         RW_BYTE: begin
            o_be    = 4'b0001 << w_lane_eff;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_sign_ext & w_sh[7]}}, w_sh[7:0]};
         end
         RW_HWORD: begin
            o_be    = 4'b0011 << w_lane_eff;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{i_sign_ext & w_sh[15]}}, w_sh[15:0]};
         end
         default: begin
            o_be    = 4'hF;
            o_wdata = i_wdata;
            o_rdata = w_sh;
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_sequencer.sv
// rtl/lsu_bus_sequencer.sv - MEM-stage load/store sequencer onto a req/gnt/rvalid bus
// Purpose: captures a MEM-stage access, drives registered bus outputs, stalls the
//          pipeline until the bus completes, returns aligned/extended load data.
//          Optional macro LSU_MISALIGN_TRAP_EN: misaligned HWORD/WORD accesses skip
//          the bus and pulse o_misalign.
// Ports:   i_clk, i_rst_n (async, active-low)
//          i_valid, i_mem_ctrl, i_addr, i_wdata      MEM-stage access
//          o_stall, o_rdata, o_rdata_valid, o_err, o_misalign   pipeline side
//          o_bus_req/we/addr/be/wdata, i_bus_gnt/rvalid/rdata   bus side
module lsu_bus_sequencer
   import rv_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   input  mem_ctrl_reg_t i_mem_ctrl,
   input  logic [31:0]   i_addr,
   input  logic [31:0]   i_wdata,
   output logic          o_stall,
   output logic [31:0]   o_rdata,
   output logic          o_rdata_valid,
   output logic          o_err,
   output logic          o_misalign,
   output logic          o_bus_req,
   output logic          o_bus_we,
   output logic [31:0]   o_bus_addr,
   output logic [3:0]    o_bus_be,
   output logic [31:0]   o_bus_wdata,
   input  logic          i_bus_gnt,
   input  logic          i_bus_rvalid,
   input  logic [31:0]   i_bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   lsu_state_e       r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   rw_sz_e           r_sz;
   logic             r_sign;
   logic [1:0]       r_lane;
   logic             r_bus_req, r_bus_we;
   logic [31:0]      r_bus_addr, r_bus_wdata, r_rdata;
   logic [3:0]       r_bus_be;
   logic             r_rdata_valid, r_err, r_misalign;

   logic             w_access, w_misalign, w_in_bus, w_done_ok, w_timeout;
   rw_sz_e           w_sz;
   logic             w_sign;
   logic [1:0]       w_lane;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata_rep, w_rdata_ext;

   assign w_access = i_valid & (i_mem_ctrl.mem_read | i_mem_ctrl.mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = lsu_misaligned(i_mem_ctrl.rw_sz, i_addr[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_in_bus  = (r_state == LSU_REQ) | (r_state == LSU_WAIT);
   assign w_done_ok = ((r_state == LSU_REQ) & i_bus_gnt & i_bus_rvalid) |
                      ((r_state == LSU_WAIT) & i_bus_rvalid);
   // A completion in the last allowed cycle wins over the timeout.
   assign w_timeout = w_in_bus & ~w_done_ok & (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // In IDLE the aligner sees the incoming access (for BE/wdata capture);
   // afterwards it sees the captured access (for load extraction).
   assign w_sz   = (r_state == LSU_IDLE) ? i_mem_ctrl.rw_sz    : r_sz;
   assign w_sign = (r_state == LSU_IDLE) ? i_mem_ctrl.sign_ext : r_sign;
   assign w_lane = (r_state == LSU_IDLE) ? i_addr[1:0]         : r_lane;

   lsu_lane_align u_align (
      .i_sz       (w_sz),
      .i_sign_ext (w_sign),
      .i_lane     (w_lane),
      .i_wdata    (i_wdata),
      .i_rdata    (i_bus_rdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata_rep),
      .o_rdata    (w_rdata_ext)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         LSU_IDLE: if (w_access) w_next = w_misalign ? LSU_DONE : LSU_REQ;
         LSU_REQ: begin
            if (w_done_ok || w_timeout) w_next = LSU_DONE;
            else if (i_bus_gnt)         w_next = LSU_WAIT;
         end
         LSU_WAIT: if (w_done_ok || w_timeout) w_next = LSU_DONE;
         default:  w_next = LSU_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= LSU_IDLE;
         r_cnt         <= '0;
         r_sz          <= RW_BYTE;
         r_sign        <= 1'b0;
         r_lane        <= 2'b00;
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_addr    <= '0;
         r_bus_be      <= '0;
         r_bus_wdata   <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_err         <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_rdata_valid <= 1'b0;
         r_err         <= 1'b0;
         r_misalign    <= 1'b0;
         case (r_state)
            LSU_IDLE: begin
               if (w_access) begin
                  r_cnt  <= '0;
                  r_sz   <= i_mem_ctrl.rw_sz;
                  r_sign <= i_mem_ctrl.sign_ext;
                  r_lane <= i_addr[1:0];
                  if (w_misalign) begin
                     r_misalign <= 1'b1;
                  end else begin
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= i_mem_ctrl.mem_write;
                     r_bus_addr  <= {i_addr[31:2], 2'b00};
                     r_bus_be    <= w_be;
                     r_bus_wdata <= w_wdata_rep;
                  end
               end
            end
            LSU_REQ, LSU_WAIT: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_state == LSU_REQ && i_bus_gnt) r_bus_req <= 1'b0;
               if (w_done_ok) begin
                  if (!r_bus_we) begin
                     r_rdata       <= w_rdata_ext;
                     r_rdata_valid <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_bus_req <= 1'b0;
                  r_rdata   <= '0;
                  r_err     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_stall       = ((r_state == LSU_IDLE) & w_access) | w_in_bus;
   assign o_rdata       = r_rdata;
   assign o_rdata_valid = r_rdata_valid;
   assign o_err         = r_err;
   assign o_misalign    = r_misalign;
   assign o_bus_req     = r_bus_req;
   assign o_bus_we      = r_bus_we;
   assign o_bus_addr    = r_bus_addr;
   assign o_bus_be      = r_bus_be;
   assign o_bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus_sequencer.sv
// tb/tb_lsu_bus_sequencer.sv - self-checking bench for lsu_bus_sequencer
module tb_lsu_bus_sequencer;
   import rv_pkg::*;

   localparam int TO = 255;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_valid;
   mem_ctrl_reg_t i_mem_ctrl;
   logic [31:0]   i_addr, i_wdata;
   logic          o_stall, o_rdata_valid, o_err, o_misalign;
   logic [31:0]   o_rdata;
   logic          o_bus_req, o_bus_we;
   logic [31:0]   o_bus_addr, o_bus_wdata;
   logic [3:0]    o_bus_be;
   logic          i_bus_gnt, i_bus_rvalid;
   logic [31:0]   i_bus_rdata;

   int            checks, errors;
   logic [31:0]   model_rdata;

   always #5 i_clk = ~i_clk;

   lsu_bus_sequencer #(.TIMEOUT_CYC(TO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_mem_ctrl(i_mem_ctrl),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_rdata(o_rdata),
      .o_rdata_valid(o_rdata_valid), .o_err(o_err), .o_misalign(o_misalign),
      .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
      .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata), .i_bus_gnt(i_bus_gnt),
      .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: an access of n bytes occupies lanes lo..lo+n-1,
   // where lo is the byte offset rounded down to a multiple of n.
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic int low_lane(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      return (int'(a % 4) / n) * n;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] be;
      int n = nbytes(sz), lo = low_lane(sz, a);
      for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + n);
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      int n = nbytes(sz);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                          input logic [31:0] a, input logic [31:0] rd);
      int n = nbytes(sz), lo = low_lane(sz, a);
      logic [31:0] v = rd >> (8 * lo);
      logic [31:0] mask = 32'hFFFF_FFFF >> (32 - 8 * n);
      v = v & mask;
      if (sx && n < 4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // Presents one MEM-stage access, plays the bus (gnt after gw request cycles,
   // rvalid rw cycles after gnt; gw >= TO means never grant) and checks the result.
   task automatic access(input logic rd, input logic wr, input logic sx, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                         input int gw, input int rw,
                         output int stalls, output int reqs, output logic [31:0] obs_rdata,
                         output logic [3:0] obs_be, output logic [31:0] obs_addr,
                         output logic [31:0] obs_wdata);
      logic is_wr = wr;
      logic is_rd = rd & ~wr;
      logic misal, tmo, granted, done;
      int   wcnt;
`ifdef LSU_MISALIGN_TRAP_EN
      misal = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
`else
      misal = 1'b0;
`endif
      tmo = !misal && (gw >= TO);
      stalls = 0; reqs = 0; wcnt = 0; granted = 0; done = 0;
      obs_rdata = '0; obs_be = '0; obs_addr = '0; obs_wdata = '0;
      i_valid = 1'b1;
      i_mem_ctrl = '{mem_read: rd, mem_write: wr, sign_ext: sx, rw_sz: rw_sz_e'(sz)};
      i_addr = addr; i_wdata = wd;
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = $urandom;
      #1;
      chk("stall_on_present", o_stall, 1'b1);
      stalls = 1;
      for (int k = 0; k < TO + 20 && !done; k++) begin
         @(posedge i_clk); #1;
         i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = $urandom;
         if (o_stall) begin
            stalls++;
            chk("bus_addr", o_bus_addr, {addr[31:2], 2'b00});
            chk("bus_be", o_bus_be, m_be(sz, addr));
            chk("bus_we", o_bus_we, is_wr);
            if (is_wr) chk("bus_wdata", o_bus_wdata, m_wdata(sz, wd));
            obs_be = o_bus_be; obs_addr = o_bus_addr; obs_wdata = o_bus_wdata;
            if (o_bus_req) begin
               reqs++;
               if (reqs > gw) begin
                  i_bus_gnt = 1'b1; granted = 1;
                  if (rw == 0) begin i_bus_rvalid = 1'b1; i_bus_rdata = rdat; end
               end
            end else if (granted) begin
               wcnt++;
               if (wcnt >= rw) begin i_bus_rvalid = 1'b1; i_bus_rdata = rdat; end
            end
         end else begin
            done = 1;
         end
      end
      chk("completed_within_bound", done, 1'b1);
      if (misal) begin
         chk("mis_pulse", o_misalign, 1'b1);
         chk("mis_reqs", reqs, 0);
         chk("mis_stalls", stalls, 1);
      end else if (tmo) begin
         model_rdata = '0;
         chk("to_err", o_err, 1'b1);
         chk("to_reqs", reqs, TO);
         chk("to_stalls", stalls, TO + 1);
      end else begin
         if (is_rd) model_rdata = m_load(sz, sx, addr, rdat);
         chk("err_low", o_err, 1'b0);
         chk("misalign_low", o_misalign, 1'b0);
         chk("stall_cycles", stalls, 1 + (gw + 1) + rw);
      end
      chk("done_valid", o_rdata_valid, (!misal && !tmo && is_rd));
      chk("done_req_low", o_bus_req, 1'b0);
      chk("done_rdata", o_rdata, model_rdata);
      obs_rdata = o_rdata;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      chk("idle_stall", o_stall, 1'b0);
      chk("idle_valid", o_rdata_valid, 1'b0);
      chk("idle_err", o_err, 1'b0);
      chk("idle_rdata_held", o_rdata, model_rdata);
   endtask

   initial begin
      int st, rq;
      logic [31:0] ord, oad, owd;
      logic [3:0]  obe;
      checks = 0; errors = 0; model_rdata = '0;
      i_rst_n = 1'b0; i_valid = 1'b0; i_mem_ctrl = '0; i_addr = '0; i_wdata = '0;
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_stall", o_stall, 1'b0);
      chk("rst_req", o_bus_req, 1'b0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_valid", o_rdata_valid, 1'b0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_misalign", o_misalign, 1'b0);
      chk("rst_be", o_bus_be, 4'h0);
      chk("rst_addr", o_bus_addr, 32'h0);
      @(negedge i_clk) i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // LB with sign extension, zero-wait bus.
      access(1, 0, 1, 2'd0, 32'h203, 32'h0, 32'h80AA_BBCC, 0, 0, st, rq, ord, obe, oad, owd);
      chk("lb_value", ord, 32'hFFFF_FF80);
      chk("lb_stalls", st, 2);

      // LHU in the upper half.
      access(1, 0, 0, 2'd1, 32'h102, 32'h0, 32'hF234_5678, 0, 1, st, rq, ord, obe, oad, owd);
      chk("lhu_be", obe, 4'b1100);
      chk("lhu_value", ord, 32'h0000_F234);

      // SH with grant after 3 cycles: request held for 4.
      access(0, 1, 0, 2'd1, 32'h102, 32'h0000_1234, 32'h0, 3, 0, st, rq, ord, obe, oad, owd);
      chk("sh_reqs", rq, 4);
      chk("sh_addr", oad, 32'h100);
      chk("sh_wdata", owd, 32'h1234_1234);
      chk("sh_rdata_unchanged", ord, 32'h0000_F234);

      // LW never granted: timeout.
      access(1, 0, 0, 2'd2, 32'h300, 32'h0, 32'h0, 1000000, 0, st, rq, ord, obe, oad, owd);
      chk("to_rdata", ord, 32'h0);

      // LW to a misaligned address.
      access(1, 0, 0, 2'd2, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 0, st, rq, ord, obe, oad, owd);
`ifndef LSU_MISALIGN_TRAP_EN
      chk("lw_mis_addr", oad, 32'h100);
      chk("lw_mis_be", obe, 4'hF);
      chk("lw_mis_value", ord, 32'hCAFE_F00D);
`endif

      // Reset asserted while waiting for rvalid.
      i_valid = 1'b1;
      i_mem_ctrl = '{mem_read: 1'b1, mem_write: 1'b0, sign_ext: 1'b0, rw_sz: RW_WORD};
      i_addr = 32'h40;
      @(posedge i_clk); #1;
      i_bus_gnt = 1'b1;
      @(posedge i_clk); #1;
      i_bus_gnt = 1'b0;
      @(posedge i_clk); #1;
      chk("wait_stall", o_stall, 1'b1);
      chk("wait_req_low", o_bus_req, 1'b0);
      #2;
      i_valid = 1'b0;
      i_rst_n = 1'b0;
      #1;
      chk("arst_stall", o_stall, 1'b0);
      chk("arst_req", o_bus_req, 1'b0);
      chk("arst_rdata", o_rdata, 32'h0);
      model_rdata = '0;
      @(negedge i_clk) i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      access(1, 0, 0, 2'd2, 32'h44, 32'h0, 32'h1357_9BDF, 1, 2, st, rq, ord, obe, oad, owd);
      chk("post_rst_value", ord, 32'h1357_9BDF);

      // Randomized accesses against the reference model.
      for (int it = 0; it < 60; it++) begin
         int kind = $urandom_range(0, 2);
         logic [1:0] sz = 2'($urandom_range(0, 2));
         logic [31:0] a = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
         if (sz == 2'd1) a[0] = 1'b0;
         if (sz == 2'd2) a[1:0] = 2'b00;
`endif
         i_valid = 1'($urandom_range(0, 1));
         i_mem_ctrl = '{mem_read: 1'b0, mem_write: 1'b0, sign_ext: 1'($urandom), rw_sz: rw_sz_e'(sz)};
         #1;
         chk("no_access_stall", o_stall, 1'b0);
         chk("no_access_req", o_bus_req, 1'b0);
         @(posedge i_clk); #1;
         access(kind != 1, kind != 0, 1'($urandom), sz, a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), st, rq, ord, obe, oad, owd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
